ex_mdu: RTL and testbench

- Iterative multiply/divide unit in the EX stage, directly downstream of the ID/EX pipeline register.
- Consumes the latched mdu_op, rs value (ex_a) and rt value (ex_b). Owns the architectural HI/LO registers.
- Returns MFHI/MFLO data to the EX result mux.
- Drives a stall request, merged into the ID/EX/MEM hold (pa_idexmemwr), while a multi-cycle operation is in flight.

---
 rtl/ex_mdu_if.sv | 23 ++
 rtl/ex_mdu.sv | 208 ++++++++++++++++++++
 tb/tb_ex_mdu.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/ex_mdu_if.sv
// ex_mdu_if: operand/control bundle between the ID/EX pipeline register
// (master side) and the EX-stage multiply/divide unit (slave side).
interface ex_mdu_if;
  logic [3:0]  mdu_op_i;
  logic [31:0] ex_a;
  logic [31:0] ex_b;
  logic        ex_stall_i;
  logic        mdu_cancel;
  logic        mdu_busy;
  logic [31:0] mdu_result;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  modport master (
    output mdu_op_i, ex_a, ex_b, ex_stall_i, mdu_cancel,
    input  mdu_busy, mdu_result, hi_o, lo_o
  );

  modport slave (
    input  mdu_op_i, ex_a, ex_b, ex_stall_i, mdu_cancel,
    output mdu_busy, mdu_result, hi_o, lo_o
  );
endinterface

// File: rtl/ex_mdu.sv
// ex_mdu: iterative multiply/divide unit owning the architectural HI/LO pair.
// Shift-add multiply (MUL_BITS_PER_CYCLE bits per step), restoring divide
// (one quotient bit per step). Signed ops run on magnitudes and fix signs on
// the last step. Optional macro MDU_FAST_MUL_EN swaps the iterative multiply
// for a single-cycle combinational one; divide is unaffected.
module ex_mdu #(
  parameter int unsigned MUL_BITS_PER_CYCLE = 1,
  parameter logic [31:0] HILO_RESET         = 32'h0000_0000
) (
  input logic     clk,
  input logic     reset,
  ex_mdu_if.slave mdu
);
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;
  localparam int         MB        = MUL_BITS_PER_CYCLE;
  localparam logic [5:0] MUL_ITERS = 6'(32 / MUL_BITS_PER_CYCLE);
  localparam logic [5:0] DIV_ITERS = 6'd32;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t      state_q, state_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [63:0] acc_q, acc_d;
  logic [63:0] mcand_q, mcand_d;
  logic [31:0] mplier_q, mplier_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] dvs_q, dvs_d;
  logic        negRes_q, negRes_d;
  logic        negRem_q, negRem_d;
  logic        divZero_q, divZero_d;

  logic        isMul, isDiv, isSigned, aNeg, bNeg, startOp, busyRaw;
  logic [31:0] aMag, bMag;
  logic [63:0] mulSum, mulFinal;
  logic [32:0] divShift;
  logic [31:0] divDiff, remNext, quoNext;
  logic        divFits;

  assign isMul    = (mdu.mdu_op_i == OP_MULT) || (mdu.mdu_op_i == OP_MULTU);
  assign isDiv    = (mdu.mdu_op_i == OP_DIV)  || (mdu.mdu_op_i == OP_DIVU);
  assign isSigned = (mdu.mdu_op_i == OP_MULT) || (mdu.mdu_op_i == OP_DIV);
  assign aNeg     = isSigned & mdu.ex_a[31];
  assign bNeg     = isSigned & mdu.ex_b[31];
  assign aMag     = aNeg ? (~mdu.ex_a + 32'd1) : mdu.ex_a;
  assign bMag     = bNeg ? (~mdu.ex_b + 32'd1) : mdu.ex_b;

`ifdef MDU_FAST_MUL_EN
  logic [63:0] fastA, fastB, fastProd;
  assign fastA    = {{32{aNeg}}, mdu.ex_a};
  assign fastB    = {{32{bNeg}}, mdu.ex_b};
  assign fastProd = fastA * fastB;
  assign startOp  = isDiv;
`else
  assign startOp  = isMul | isDiv;
`endif

  // One multiply step: add the shifted multiplicand for each consumed multiplier bit
  always_comb begin
    mulSum = acc_q;
    for (int k = 0; k < MB; k++) begin
      if (mplier_q[k]) mulSum = mulSum + (mcand_q << k);
    end
    mulFinal = negRes_q ? (~mulSum + 64'd1) : mulSum;
  end

  // One restoring-divide step: shift in the next dividend bit, subtract if it fits
  always_comb begin
    divShift = {rem_q, quo_q[31]};
    divFits  = divShift >= {1'b0, dvs_q};
    divDiff  = divShift[31:0] - dvs_q;
    remNext  = divFits ? divDiff : divShift[31:0];
    quoNext  = {quo_q[30:0], divFits};
  end

  // Next-state and datapath control; a cancel discards everything at the end
  always_comb begin
    state_d   = state_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    negRes_d  = negRes_q;
    negRem_d  = negRem_q;
    divZero_d = divZero_q;
    case (state_q)
      IDLE: begin
        negRes_d  = aNeg ^ bNeg;
        negRem_d  = aNeg;
        divZero_d = (mdu.ex_b == 32'd0);
        if (isMul) begin
`ifdef MDU_FAST_MUL_EN
          {hi_d, lo_d} = fastProd;
`else
          state_d  = MUL;
          cnt_d    = MUL_ITERS;
          acc_d    = 64'd0;
          mcand_d  = {32'd0, aMag};
          mplier_d = bMag;
`endif
        end else if (isDiv) begin
          state_d = DIV;
          cnt_d   = DIV_ITERS;
          rem_d   = 32'd0;
          quo_d   = aMag;
          dvs_d   = bMag;
        end else if (mdu.mdu_op_i == OP_MTHI) begin
          hi_d = mdu.ex_a;
        end else if (mdu.mdu_op_i == OP_MTLO) begin
          lo_d = mdu.ex_a;
        end
      end
      MUL: begin
        acc_d    = mulSum;
        mcand_d  = mcand_q << MUL_BITS_PER_CYCLE;
        mplier_d = mplier_q >> MUL_BITS_PER_CYCLE;
        cnt_d    = cnt_q - 6'd1;
        if (cnt_q == 6'd1) begin
          {hi_d, lo_d} = mulFinal;
          state_d      = DONE;
        end
      end
      DIV: begin
        rem_d = remNext;
        quo_d = quoNext;
        cnt_d = cnt_q - 6'd1;
        if (cnt_q == 6'd1) begin
          lo_d    = divZero_q ? 32'hFFFF_FFFF : (negRes_q ? (~quoNext + 32'd1) : quoNext);
          hi_d    = negRem_q ? (~remNext + 32'd1) : remNext;
          state_d = DONE;
        end
      end
      DONE: begin
        if (!mdu.ex_stall_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (mdu.mdu_cancel) begin
      state_d = IDLE;
      hi_d    = hi_q;
      lo_d    = lo_q;
      cnt_d   = 6'd0;
    end
  end

  // Stall request: held for the issue cycle and every iteration, released in DONE
  always_comb begin
    busyRaw = 1'b0;
    case (state_q)
      MUL, DIV: busyRaw = 1'b1;
      IDLE:     busyRaw = startOp & ~mdu.mdu_cancel;
      default:  busyRaw = 1'b0;
    endcase
  end

  assign mdu.mdu_busy   = reset & busyRaw;
  assign mdu.mdu_result = !reset ? 32'd0 :
                          (mdu.mdu_op_i == OP_MFHI) ? hi_q :
                          (mdu.mdu_op_i == OP_MFLO) ? lo_q : 32'd0;
  assign mdu.hi_o       = hi_q;
  assign mdu.lo_o       = lo_q;

  // State and datapath registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      hi_q      <= HILO_RESET;
      lo_q      <= HILO_RESET;
      cnt_q     <= 6'd0;
      acc_q     <= 64'd0;
      mcand_q   <= 64'd0;
      mplier_q  <= 32'd0;
      rem_q     <= 32'd0;
      quo_q     <= 32'd0;
      dvs_q     <= 32'd0;
      negRes_q  <= 1'b0;
      negRem_q  <= 1'b0;
      divZero_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      negRes_q  <= negRes_d;
      negRem_q  <= negRem_d;
      divZero_q <= divZero_d;
    end
  end
endmodule

// File: tb/tb_ex_mdu.sv
// tb_ex_mdu: randomized and directed checks of ex_mdu against an arithmetic
// reference model of HI/LO and of the expected stall length per operation.
module tb_ex_mdu;
  localparam int unsigned BPC      = 1;
  localparam logic [31:0] RST_VAL  = 32'h1357_9BDF;
  localparam logic [3:0]  NOP      = 4'd0;
  localparam logic [3:0]  MULT     = 4'd1;
  localparam logic [3:0]  MULTU    = 4'd2;
  localparam logic [3:0]  DIV      = 4'd3;
  localparam logic [3:0]  DIVU     = 4'd4;
  localparam logic [3:0]  MFHI     = 4'd5;
  localparam logic [3:0]  MFLO     = 4'd6;
  localparam logic [3:0]  MTHI     = 4'd7;
  localparam logic [3:0]  MTLO     = 4'd8;

  logic        clk;
  logic        reset;
  int          vecCount = 0;
  int          errCount = 0;
  logic [31:0] mHi, mLo;

  ex_mdu_if mdu();

  ex_mdu #(.MUL_BITS_PER_CYCLE(BPC), .HILO_RESET(RST_VAL)) dut (
    .clk   (clk),
    .reset (reset),
    .mdu   (mdu)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expectation and log a miscompare
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vecCount++;
    if (observed !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  // Expected number of cycles the MDU holds the pipeline for one instruction
  function automatic int expBusy(input logic [3:0] op);
    if (op == MULT || op == MULTU) begin
`ifdef MDU_FAST_MUL_EN
      return 0;
`else
      return 1 + 32 / BPC;
`endif
    end
    if (op == DIV || op == DIVU) return 33;
    return 0;
  endfunction

  // Architectural effect of one completed instruction on HI/LO
  task automatic refModel(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      sp;
    logic [63:0] up;
    int          sa, sb;
    sa = a;
    sb = b;
    case (op)
      MULT: begin
        sp = longint'(sa) * longint'(sb);
        {mHi, mLo} = sp;
      end
      MULTU: begin
        up = {32'd0, a} * {32'd0, b};
        {mHi, mLo} = up;
      end
      DIV: begin
        if (b == 32'd0) begin mLo = 32'hFFFF_FFFF; mHi = a; end
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin mLo = 32'h8000_0000; mHi = 32'd0; end
        else begin mLo = sa / sb; mHi = sa % sb; end
      end
      DIVU: begin
        if (b == 32'd0) begin mLo = 32'hFFFF_FFFF; mHi = a; end
        else begin mLo = a / b; mHi = a % b; end
      end
      MTHI: mHi = a;
      MTLO: mLo = a;
      default: ;
    endcase
  endtask

  // Issue one instruction, measure its stall, optionally hold it in EX, then retire it
  task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input int stallExtra);
    int          busyCycles;
    logic [31:0] expRes;
    expRes = (op == MFHI) ? mHi : (op == MFLO) ? mLo : 32'd0;
    mdu.mdu_op_i = op;
    mdu.ex_a     = a;
    mdu.ex_b     = b;
    #1;
    checkOutput("result", mdu.mdu_result, expRes);
    busyCycles = 0;
    while (mdu.mdu_busy === 1'b1 && busyCycles < 100) begin
      busyCycles++;
      @(posedge clk); #1;
    end
    checkOutput("busy_cycles", busyCycles, expBusy(op));
    refModel(op, a, b);
    for (int i = 0; i < stallExtra; i++) begin
      mdu.ex_stall_i = 1'b1;
      #1;
      checkOutput("stall_busy", {31'd0, mdu.mdu_busy}, 32'd0);
      if (expBusy(op) > 0) checkOutput("stall_hi", mdu.hi_o, mHi);
      @(posedge clk); #1;
    end
    mdu.ex_stall_i = 1'b0;
    @(posedge clk); #1;
    mdu.mdu_op_i = NOP;
    #1;
    checkOutput("hi", mdu.hi_o, mHi);
    checkOutput("lo", mdu.lo_o, mLo);
    checkOutput("idle_busy", {31'd0, mdu.mdu_busy}, 32'd0);
  endtask

  function automatic logic [31:0] pickVal();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [3:0] opList [9];
    opList = '{MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI, MTLO, 4'd11};

    reset          = 1'b0;
    mdu.mdu_op_i   = DIV;
    mdu.ex_a       = 32'd5;
    mdu.ex_b       = 32'd1;
    mdu.ex_stall_i = 1'b0;
    mdu.mdu_cancel = 1'b0;
    #12;
    checkOutput("rst_busy", {31'd0, mdu.mdu_busy}, 32'd0);
    checkOutput("rst_hi", mdu.hi_o, RST_VAL);
    checkOutput("rst_lo", mdu.lo_o, RST_VAL);
    mdu.mdu_op_i = MFHI;
    #1;
    checkOutput("rst_result", mdu.mdu_result, 32'd0);
    mdu.mdu_op_i = NOP;
    #2 reset = 1'b1;
    mHi = RST_VAL;
    mLo = RST_VAL;
    @(posedge clk); #1;

    $display("[TB] directed operations");
    applyStimulus(MFHI, 32'd0, 32'd0, 0);
    applyStimulus(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    applyStimulus(MFHI, 32'd0, 32'd0, 0);
    applyStimulus(DIV, -32'sd7, 32'd2, 0);
    applyStimulus(DIVU, 32'd100, 32'd0, 0);
    applyStimulus(DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    applyStimulus(DIV, -32'sd9, 32'd0, 0);
    applyStimulus(MULT, -32'sd3, 32'd5, 4);
    applyStimulus(MULT, 32'h8000_0000, 32'd2, 0);
    applyStimulus(MFLO, 32'd0, 32'd0, 2);

    $display("[TB] cancel behaviour");
    applyStimulus(MTLO, 32'h0000_1234, 32'd0, 0);
    applyStimulus(MTHI, 32'h0000_5678, 32'd0, 0);
    mdu.mdu_op_i = DIV; mdu.ex_a = 32'd100; mdu.ex_b = 32'd7;
    #1;
    checkOutput("cancel_issue_busy", {31'd0, mdu.mdu_busy}, 32'd1);
    repeat (11) @(posedge clk);
    #1 mdu.mdu_cancel = 1'b1;
    #1 checkOutput("cancel_mid_busy", {31'd0, mdu.mdu_busy}, 32'd1);
    @(posedge clk); #1;
    mdu.mdu_cancel = 1'b0; mdu.mdu_op_i = NOP;
    #1;
    checkOutput("cancel_mid_idle", {31'd0, mdu.mdu_busy}, 32'd0);
    repeat (40) @(posedge clk);
    #1;
    checkOutput("cancel_mid_hi", mdu.hi_o, mHi);
    checkOutput("cancel_mid_lo", mdu.lo_o, mLo);
    mdu.mdu_op_i = DIV; mdu.ex_a = 32'd99; mdu.ex_b = 32'd4;
    repeat (32) @(posedge clk);
    #1 mdu.mdu_cancel = 1'b1;
    @(posedge clk); #1;
    mdu.mdu_cancel = 1'b0; mdu.mdu_op_i = NOP;
    #1;
    checkOutput("cancel_last_busy", {31'd0, mdu.mdu_busy}, 32'd0);
    checkOutput("cancel_last_hi", mdu.hi_o, mHi);
    checkOutput("cancel_last_lo", mdu.lo_o, mLo);
    mdu.mdu_op_i = DIV; mdu.mdu_cancel = 1'b1;
    #1 checkOutput("cancel_idle_busy", {31'd0, mdu.mdu_busy}, 32'd0);
    @(posedge clk); #1;
    checkOutput("cancel_idle_nostart", {31'd0, mdu.mdu_busy}, 32'd0);
    mdu.mdu_op_i = MTHI; mdu.ex_a = 32'hCAFE_0000;
    @(posedge clk); #1;
    checkOutput("cancel_mthi", mdu.hi_o, mHi);
    mdu.mdu_cancel = 1'b0; mdu.mdu_op_i = NOP;
    #1 checkOutput("after_cancel_busy", {31'd0, mdu.mdu_busy}, 32'd0);

    $display("[TB] asynchronous reset mid-divide");
    applyStimulus(MTHI, 32'hDEAD_BEEF, 32'd0, 0);
    mdu.mdu_op_i = DIV; mdu.ex_a = 32'd1000; mdu.ex_b = 32'd3;
    repeat (6) @(posedge clk);
    #3 reset = 1'b0;
    #1;
    checkOutput("amid_busy", {31'd0, mdu.mdu_busy}, 32'd0);
    checkOutput("amid_hi", mdu.hi_o, RST_VAL);
    checkOutput("amid_lo", mdu.lo_o, RST_VAL);
    mdu.mdu_op_i = NOP;
    #2 reset = 1'b1;
    mHi = RST_VAL;
    mLo = RST_VAL;
    @(posedge clk); #1;

    $display("[TB] randomized operations");
    for (int n = 0; n < 40; n++) begin
      applyStimulus(opList[$urandom_range(0, 8)], pickVal(), pickVal(), int'($urandom_range(0, 2)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
    $finish;
  end
endmodule
